// File: rtl/vga_pkg.sv
// Shared VGA timing sets and helpers for the raster generator and its axis counters.
package vga_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{
    h: '{active: 640, fp: 16, sync: 96,  bp: 48},
    v: '{active: 480, fp: 10, sync: 2,   bp: 33}
  };

  localparam vga_timing_t VGA_800x600_72 = '{
    h: '{active: 800, fp: 56, sync: 120, bp: 64},
    v: '{active: 600, fp: 37, sync: 6,   bp: 23}
  };

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input vga_timing_t t);
    return axis_total(t.h.active, t.h.fp, t.h.sync, t.h.bp);
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return axis_total(t.v.active, t.v.fp, t.v.sync, t.v.bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with terminal flag, raw sync window and
// a registered active flag computed from the next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_raw,
  output logic             active
);

  localparam int               TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [31:0]      SYNC_LO = 32'(ACTIVE + FP);
  localparam logic [31:0]      SYNC_HI = 32'(ACTIVE + FP + SYNC);
  localparam logic [31:0]      ACT_HI  = 32'(ACTIVE);

  logic [CNT_W-1:0] count_nxt;

  assign wrap     = (count == LAST);
  // Compared at 32 bits so a window ending exactly at 2^CNT_W still works.
  assign sync_raw = (32'(count) >= SYNC_LO) && (32'(count) < SYNC_HI);

  always_comb begin
    count_nxt = count;
    if (inc) count_nxt = wrap ? '0 : count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      active <= 1'b1;
    end else begin
      count  <= count_nxt;
      active <= (32'(count_nxt) < ACT_HI);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V counters, line/frame strobes, and a one-pixel output
// stage that registers syncs together with blank-gated renderer colour.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_640x480_60.h.active,
  parameter int H_FP      = VGA_640x480_60.h.fp,
  parameter int H_SYNC    = VGA_640x480_60.h.sync,
  parameter int H_BP      = VGA_640x480_60.h.bp,
  parameter int V_ACTIVE  = VGA_640x480_60.v.active,
  parameter int V_FP      = VGA_640x480_60.v.fp,
  parameter int V_SYNC    = VGA_640x480_60.v.sync,
  parameter int V_BP      = VGA_640x480_60.v.bp,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10,
  parameter int COLOR_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               video_active,
  output logic               line_start,
  output logic               frame_start,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_w_check
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic h_wrap, v_wrap, h_sync_raw, v_sync_raw, h_active, v_active;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .reset(reset), .inc(pix_en),
    .count(hcount), .wrap(h_wrap), .sync_raw(h_sync_raw), .active(h_active)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .reset(reset), .inc(pix_en & h_wrap),
    .count(vcount), .wrap(v_wrap), .sync_raw(v_sync_raw), .active(v_active)
  );

  assign video_active = h_active & v_active;

  // Strobes fire only on an actual wrap, so reset landing on (0,0) never pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en & h_wrap;
      frame_start <= pix_en & h_wrap & v_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else if (pix_en) begin
      hsync <= h_sync_raw ? HSYNC_POL : ~HSYNC_POL;
      vsync <= v_sync_raw ? VSYNC_POL : ~VSYNC_POL;
      r     <= video_active ? r_in : '0;
      g     <= video_active ? g_in : '0;
      b     <= video_active ? b_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three configurations of vga_timing_gen checked every cycle against a pixel-index model,
// plus hand-computed timing measurements (sync widths, strobe periods, reset recovery).
module tb_vga_timing_gen;

  typedef struct packed {
    int h_act, h_fp, h_sync, h_bp;
    int v_act, v_fp, v_sync, v_bp;
    bit hp, vp;
  } cfg_t;

  localparam cfg_t CA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam cfg_t CB = '{40, 4, 8, 4, 30, 3, 2, 5, 1'b1, 1'b1};
  localparam cfg_t CC = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0};
  localparam int AW = 10, BW = 6, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  logic rst_a, pe_a, rst_b, pe_b, rst_c, pe_c;
  logic [AW-1:0] hc_a, vc_a;
  logic [BW-1:0] hc_b, vc_b;
  logic [CW-1:0] hc_c, vc_c;
  logic act_a, ls_a, fs_a, hs_a, vs_a, act_b, ls_b, fs_b, hs_b, vs_b, act_c, ls_c, fs_c, hs_c, vs_c;
  logic [3:0] ri_a, gi_a, bi_a, r_a, g_a, b_a;
  logic [3:0] ri_b, gi_b, bi_b, r_b, g_b, b_b;
  logic [3:0] ri_c, gi_c, bi_c, r_c, g_c, b_c;

  // Renderer stand-in: a combinational pattern of the current position.
  assign ri_a = hc_a[3:0]; assign gi_a = vc_a[3:0]; assign bi_a = hc_a[3:0] + vc_a[3:0];
  assign ri_b = hc_b[3:0]; assign gi_b = vc_b[3:0]; assign bi_b = hc_b[3:0] + vc_b[3:0];
  assign ri_c = hc_c[3:0]; assign gi_c = vc_c[3:0]; assign bi_c = hc_c[3:0] + vc_c[3:0];

  vga_timing_gen #(
    .H_ACTIVE(CA.h_act), .H_FP(CA.h_fp), .H_SYNC(CA.h_sync), .H_BP(CA.h_bp),
    .V_ACTIVE(CA.v_act), .V_FP(CA.v_fp), .V_SYNC(CA.v_sync), .V_BP(CA.v_bp),
    .HSYNC_POL(CA.hp), .VSYNC_POL(CA.vp), .CNT_W(AW), .COLOR_W(4)
  ) dut_a (
    .clk(clk), .reset(rst_a), .pix_en(pe_a), .hcount(hc_a), .vcount(vc_a),
    .video_active(act_a), .line_start(ls_a), .frame_start(fs_a),
    .r_in(ri_a), .g_in(gi_a), .b_in(bi_a), .hsync(hs_a), .vsync(vs_a), .r(r_a), .g(g_a), .b(b_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(CB.h_act), .H_FP(CB.h_fp), .H_SYNC(CB.h_sync), .H_BP(CB.h_bp),
    .V_ACTIVE(CB.v_act), .V_FP(CB.v_fp), .V_SYNC(CB.v_sync), .V_BP(CB.v_bp),
    .HSYNC_POL(CB.hp), .VSYNC_POL(CB.vp), .CNT_W(BW), .COLOR_W(4)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_en(pe_b), .hcount(hc_b), .vcount(vc_b),
    .video_active(act_b), .line_start(ls_b), .frame_start(fs_b),
    .r_in(ri_b), .g_in(gi_b), .b_in(bi_b), .hsync(hs_b), .vsync(vs_b), .r(r_b), .g(g_b), .b(b_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(CC.h_act), .H_FP(CC.h_fp), .H_SYNC(CC.h_sync), .H_BP(CC.h_bp),
    .V_ACTIVE(CC.v_act), .V_FP(CC.v_fp), .V_SYNC(CC.v_sync), .V_BP(CC.v_bp),
    .HSYNC_POL(CC.hp), .VSYNC_POL(CC.vp), .CNT_W(CW), .COLOR_W(4)
  ) dut_c (
    .clk(clk), .reset(rst_c), .pix_en(pe_c), .hcount(hc_c), .vcount(vc_c),
    .video_active(act_c), .line_start(ls_c), .frame_start(fs_c),
    .r_in(ri_c), .g_in(gi_c), .b_in(bi_c), .hsync(hs_c), .vsync(vs_c), .r(r_c), .g(g_c), .b(b_c)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: k = pixel advances since reset; position and outputs follow by arithmetic.
  task automatic check_dut(input string dn, input cfg_t c, input int k, input bit adv,
                           input logic [31:0] hc, input logic [31:0] vc,
                           input logic va, input logic ls, input logic fs,
                           input logic hs, input logic vs,
                           input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    int ht, vt, h, v, p, ph, pv, er, eg, eb;
    bit e_hs, e_vs;
    ht = c.h_act + c.h_fp + c.h_sync + c.h_bp;
    vt = c.v_act + c.v_fp + c.v_sync + c.v_bp;
    h = k % ht;
    v = (k / ht) % vt;
    cmp({dn, ".hcount"}, hc, 32'(h));
    cmp({dn, ".vcount"}, vc, 32'(v));
    cmp({dn, ".video_active"}, 32'(va), 32'(h < c.h_act && v < c.v_act));
    cmp({dn, ".line_start"}, 32'(ls), 32'(adv && h == 0));
    cmp({dn, ".frame_start"}, 32'(fs), 32'(adv && h == 0 && v == 0));
    e_hs = !c.hp; e_vs = !c.vp; er = 0; eg = 0; eb = 0;
    if (k > 0) begin
      p  = k - 1;
      ph = p % ht;
      pv = (p / ht) % vt;
      if (ph >= c.h_act + c.h_fp && ph < c.h_act + c.h_fp + c.h_sync) e_hs = c.hp;
      if (pv >= c.v_act + c.v_fp && pv < c.v_act + c.v_fp + c.v_sync) e_vs = c.vp;
      if (ph < c.h_act && pv < c.v_act) begin
        er = ph % 16; eg = pv % 16; eb = (ph + pv) % 16;
      end
    end
    cmp({dn, ".hsync"}, 32'(hs), 32'(e_hs));
    cmp({dn, ".vsync"}, 32'(vs), 32'(e_vs));
    cmp({dn, ".r"}, r, 32'(er));
    cmp({dn, ".g"}, g, 32'(eg));
    cmp({dn, ".b"}, b, 32'(eb));
  endtask

  int k_a = 0, k_b = 0, k_c = 0;
  bit adv_a = 0, adv_b = 0, adv_c = 0;

  always @(posedge clk) begin
    k_a <= rst_a ? 0 : k_a + int'(pe_a); adv_a <= !rst_a && pe_a;
    k_b <= rst_b ? 0 : k_b + int'(pe_b); adv_b <= !rst_b && pe_b;
    k_c <= rst_c ? 0 : k_c + int'(pe_c); adv_c <= !rst_c && pe_c;
  end

  always @(negedge clk)
    check_dut("A", CA, k_a, adv_a, 32'(hc_a), 32'(vc_a), act_a, ls_a, fs_a, hs_a, vs_a,
              32'(r_a), 32'(g_a), 32'(b_a));
  always @(negedge clk)
    check_dut("B", CB, k_b, adv_b, 32'(hc_b), 32'(vc_b), act_b, ls_b, fs_b, hs_b, vs_b,
              32'(r_b), 32'(g_b), 32'(b_b));
  always @(negedge clk)
    check_dut("C", CC, k_c, adv_c, 32'(hc_c), 32'(vc_c), act_c, ls_c, fs_c, hs_c, vs_c,
              32'(r_c), 32'(g_c), 32'(b_c));

  // Timing measurements in clk cycles, first occurrence only.
  int cyc = 0;
  int a_run = 0, a_hrun = 0, a_fall_h = -1, a_prev_h = 0, a_hmax = 0, a_ls_last = -1, a_ls_per = 0;
  logic a_prev_hs = 1'b1;
  int b_hr = 0, b_hrun = 0, b_vr = 0, b_vrun = 0;
  int b_ls_last = -1, b_ls_per = 0, b_fs_last = -1, b_fs_per = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!hs_a) a_run <= a_run + 1;
    else begin
      if (a_run != 0 && a_hrun == 0) a_hrun <= a_run;
      a_run <= 0;
    end
    if (a_prev_hs && !hs_a && a_fall_h < 0) a_fall_h <= a_prev_h;
    a_prev_hs <= hs_a;
    a_prev_h  <= int'(hc_a);
    if (int'(hc_a) > a_hmax) a_hmax <= int'(hc_a);
    if (ls_a) begin
      if (a_ls_last >= 0 && a_ls_per == 0) a_ls_per <= cyc - a_ls_last;
      a_ls_last <= cyc;
    end
    if (hs_b) b_hr <= b_hr + 1;
    else begin
      if (b_hr != 0 && b_hrun == 0) b_hrun <= b_hr;
      b_hr <= 0;
    end
    if (vs_b) b_vr <= b_vr + 1;
    else begin
      if (b_vr != 0 && b_vrun == 0) b_vrun <= b_vr;
      b_vr <= 0;
    end
    if (ls_b) begin
      if (b_ls_last >= 0 && b_ls_per == 0) b_ls_per <= cyc - b_ls_last;
      b_ls_last <= cyc;
    end
    if (fs_b) begin
      if (b_fs_last >= 0 && b_fs_per == 0) b_fs_per <= cyc - b_fs_last;
      b_fs_last <= cyc;
    end
  end

  task automatic drv_a();
    int n = 0;
    while (!(hc_a == 10'd300 && vc_a == 10'd2) && n < 5000) begin
      @(posedge clk); #2; n++;
    end
    cmp("A.reach_300_2", 32'(n < 5000), 32'd1);
    rst_a = 1'b1;
    @(posedge clk); #2 rst_a = 1'b0;
    @(negedge clk);
    cmp("A.midreset_hcount", 32'(hc_a), 32'd0);
    cmp("A.midreset_vcount", 32'(vc_a), 32'd0);
    cmp("A.midreset_frame_start", 32'(fs_a), 32'd0);
    repeat (600) @(posedge clk);
  endtask

  task automatic drv_b();
    repeat (9300) begin
      @(posedge clk); #2 pe_b = !pe_b;
    end
  endtask

  task automatic drv_c();
    int n = 0;
    repeat (340) @(posedge clk);
    #2 rst_c = 1'b1;
    @(posedge clk); #2 rst_c = 1'b0;
    do begin
      @(posedge clk); #1; n++;
    end while (fs_c !== 1'b1 && n < 200);
    cmp("C.first_frame_clks", 32'(n), 32'd98);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2 pe_c = ((i % 7) != 3) && ((i % 5) != 1);
    end
    pe_c = 1'b1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    pe_a  = 1'b1; pe_b  = 1'b1; pe_c  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("A.reset_hcount", 32'(hc_a), 32'd0);
    cmp("A.reset_vcount", 32'(vc_a), 32'd0);
    cmp("A.reset_hsync", 32'(hs_a), 32'd1);
    cmp("A.reset_vsync", 32'(vs_a), 32'd1);
    cmp("A.reset_r", 32'(r_a), 32'd0);
    cmp("A.reset_frame_start", 32'(fs_a), 32'd0);
    cmp("B.reset_hsync_idle", 32'(hs_b), 32'd0);
    @(posedge clk); #2;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    fork
      drv_a();
      drv_b();
      drv_c();
    join
    @(negedge clk);
    cmp("A.hsync_fall_after_hcount", 32'(a_fall_h), 32'd656);
    cmp("A.hsync_low_clks", 32'(a_hrun), 32'd96);
    cmp("A.line_period", 32'(a_ls_per), 32'd800);
    cmp("A.hcount_max", 32'(a_hmax), 32'd799);
    cmp("B.hsync_high_clks", 32'(b_hrun), 32'd16);
    cmp("B.vsync_high_clks", 32'(b_vrun), 32'd224);
    cmp("B.line_period", 32'(b_ls_per), 32'd112);
    cmp("B.frame_period", 32'(b_fs_per), 32'd4480);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
